fpu_result_queue: RTL and testbench

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

---
 rtl/fpu_result_queue.sv | 85 ++++++++
 tb/tb_fpu_result_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_queue.sv
// Result FIFO between the FP adder and its consumer: stores packed result,
// exception flags and precision, and keeps a sticky OR of accepted flags.
module fpu_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_fp,
    input  logic [4:0]                 in_ieee,
    input  logic                       in_db,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_fp,
    output logic [4:0]                 out_ieee,
    output logic                       out_db,
    output logic [4:0]                 flags_sticky,
    input  logic                       flags_clr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   mem_fp   [DEPTH];
    logic [4:0]    mem_ieee [DEPTH];
    logic          mem_db   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          rdy_en;
    logic          push;
    logic          pop;

    // Single-precision results live in the upper word; the lower word is junk.
    function automatic logic [63:0] pack_fp(input logic [63:0] fp, input logic db);
        return db ? fp : {fp[63:32], 32'h0};
    endfunction

    // rdy_en holds in_ready low through reset and until the first edge after it.
    assign in_ready  = rdy_en && (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_fp   = out_valid ? mem_fp[rd_ptr]   : 64'h0;
    assign out_ieee = out_valid ? mem_ieee[rd_ptr] : 5'h0;
    assign out_db   = out_valid ? mem_db[rd_ptr]   : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_fp[wr_ptr]   <= pack_fp(in_fp, in_db);
            mem_ieee[wr_ptr] <= in_ieee;
            mem_db[wr_ptr]   <= in_db;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            rdy_en       <= 1'b0;
            flags_sticky <= 5'h0;
        end else begin
            rdy_en <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear takes priority but the entry accepted on the same edge survives it.
            if (flags_clr)
                flags_sticky <= push ? in_ieee : 5'h0;
            else if (push)
                flags_sticky <= flags_sticky | in_ieee;
        end
    end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Bench for fpu_result_queue: directed literal checks plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_fpu_result_queue;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_fp;
    logic [4:0]    in_ieee;
    logic          in_db;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_fp;
    logic [4:0]    out_ieee;
    logic          out_db;
    logic [4:0]    flags_sticky;
    logic          flags_clr;
    logic [CW-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    fpu_result_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fp(in_fp), .in_ieee(in_ieee), .in_db(in_db),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fp(out_fp), .out_ieee(out_ieee), .out_db(out_db),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of entries plus a sticky flag word.
    logic [63:0] q_fp[$];
    logic [4:0]  q_ieee[$];
    logic        q_db[$];
    logic [4:0]  m_sticky;
    logic        m_started;

    function automatic logic m_in_ready();
        return m_started && (q_fp.size() < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_fp.delete();
            q_ieee.delete();
            q_db.delete();
            m_sticky  = 5'h0;
            m_started = 1'b0;
        end else begin
            logic do_push;
            logic do_pop;
            do_push = in_valid && m_in_ready();
            do_pop  = out_ready && (q_fp.size() != 0);
            if (do_pop) begin
                void'(q_fp.pop_front());
                void'(q_ieee.pop_front());
                void'(q_db.pop_front());
            end
            if (do_push) begin
                q_fp.push_back(in_db ? in_fp : {in_fp[63:32], 32'h0});
                q_ieee.push_back(in_ieee);
                q_db.push_back(in_db);
            end
            if (flags_clr)
                m_sticky = do_push ? in_ieee : 5'h0;
            else if (do_push)
                m_sticky = m_sticky | in_ieee;
            m_started = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic nonempty;
        nonempty = (q_fp.size() != 0);
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("out_valid", 64'(out_valid), 64'(nonempty));
        chk("count", 64'(count), 64'(q_fp.size()));
        chk("out_fp", out_fp, nonempty ? q_fp[0] : 64'h0);
        chk("out_ieee", 64'(out_ieee), nonempty ? 64'(q_ieee[0]) : 64'h0);
        chk("out_db", 64'(out_db), nonempty ? 64'(q_db[0]) : 64'h0);
        chk("flags_sticky", 64'(flags_sticky), 64'(m_sticky));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int thr;
        rst_n = 1'b0; in_valid = 1'b0; in_fp = 64'h0; in_ieee = 5'h0;
        in_db = 1'b1; out_ready = 1'b0; flags_clr = 1'b0;
        #1;
        chk("rst count", 64'(count), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_fp", out_fp, 64'h0);
        chk("rst flags", 64'(flags_sticky), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", 64'(in_ready), 64'd0);
        cyc();
        chk("in_ready after release", 64'(in_ready), 64'd1);

        // 3.0 + 3.0 = 6.0 round trip
        in_valid = 1'b1; in_fp = 64'h4018000000000000; in_ieee = 5'h0; in_db = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("dbl out_valid", 64'(out_valid), 64'd1);
        chk("dbl out_fp", out_fp, 64'h4018000000000000);
        cyc();
        chk("dbl drained", 64'(count), 64'd0);

        // Single precision masks the low word
        out_ready = 1'b0; in_valid = 1'b1; in_fp = 64'h41A00000DEADBEEF; in_db = 1'b0;
        cyc();
        in_valid = 1'b0; in_db = 1'b1;
        chk("sgl out_fp", out_fp, 64'h41A0000000000000);
        chk("sgl out_db", 64'(out_db), 64'd0);
        out_ready = 1'b1;
        cyc();

        // Fill to DEPTH with the fifth entry held, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_fp = 64'(i);
            cyc();
        end
        chk("full count", 64'(count), 64'd4);
        chk("full in_ready", 64'(in_ready), 64'd0);
        in_fp = 64'd5;
        cyc(); cyc();
        chk("held count", 64'(count), 64'd4);
        chk("held head", out_fp, 64'd1);
        out_ready = 1'b1;
        cyc();
        chk("drain head2", out_fp, 64'd2);
        chk("drain count3", 64'(count), 64'd3);
        cyc();
        in_valid = 1'b0;
        chk("drain head3", out_fp, 64'd3);
        chk("drain count3b", 64'(count), 64'd3);
        cyc();
        chk("drain head4", out_fp, 64'd4);
        cyc();
        chk("drain head5", out_fp, 64'd5);
        cyc();
        chk("drain empty", 64'(out_valid), 64'd0);

        // Sticky flags, clear with and without accept
        out_ready = 1'b0; flags_clr = 1'b1;
        cyc();
        flags_clr = 1'b0;
        chk("flags cleared", 64'(flags_sticky), 64'd0);
        in_valid = 1'b1; in_ieee = 5'b00100;
        cyc();
        in_ieee = 5'b10000;
        cyc();
        chk("flags or", 64'(flags_sticky), 64'(5'b10100));
        flags_clr = 1'b1; in_ieee = 5'b00001;
        cyc();
        flags_clr = 1'b0; in_valid = 1'b0; in_ieee = 5'h0;
        chk("flags clr+push", 64'(flags_sticky), 64'(5'b00001));
        out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("flags after pops", 64'(flags_sticky), 64'(5'b00001));
        chk("flags drain count", 64'(count), 64'd0);

        // Steady push+pop at count 2 wraps the pointers
        out_ready = 1'b0; in_valid = 1'b1; in_fp = 64'd100;
        cyc();
        in_fp = 64'd101;
        cyc();
        chk("wrap start count", 64'(count), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_fp = 64'(102 + k);
            cyc();
            chk("wrap count", 64'(count), 64'd2);
            chk("wrap head", out_fp, 64'(101 + k));
        end
        in_valid = 1'b0;
        cyc();
        chk("wrap tail head", out_fp, 64'd109);
        cyc();

        // Asynchronous reset with entries and flags pending
        out_ready = 1'b0; in_valid = 1'b1; in_ieee = 5'b00010;
        cyc(); cyc(); cyc();
        in_valid = 1'b0; in_ieee = 5'h0;
        chk("pre-rst count", 64'(count), 64'd3);
        chk("pre-rst flags", 64'(flags_sticky), 64'(5'b00011));
        rst_n = 1'b0;
        #1;
        chk("async count", 64'(count), 64'd0);
        chk("async out_valid", 64'(out_valid), 64'd0);
        chk("async flags", 64'(flags_sticky), 64'd0);
        chk("async in_ready", 64'(in_ready), 64'd0);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("post-rst in_ready", 64'(in_ready), 64'd1);
        chk("no replay", 64'(out_valid), 64'd0);

        // Randomized traffic, checked every cycle by the compare process
        thr = 6;
        for (int n = 0; n < 2000; n++) begin
            if (n % 250 == 0)
                thr = (thr == 6) ? 2 : 6;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 7) < thr);
            in_fp     = {$urandom, $urandom};
            in_ieee   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'h0;
            in_db     = 1'($urandom_range(0, 1));
            flags_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end
        in_valid = 1'b0; flags_clr = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
